// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the program counter and drives the combinational
// instruction memory. Each fetched {pc, instruction} pair goes into a small
// FIFO, and decode drains that FIFO over a valid/ready handshake.
// A redirect reloads the PC and flushes the FIFO.
// The optional performance counters are built only when FETCH_PERF_EN is defined.
module instruction_fetch #(
  parameter int unsigned IMEM_BYTES = 32,
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  input  logic        stall_fetch,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_flush
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] PC_MASK    = 32'(IMEM_BYTES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {FETCH, HOLD} fetch_state_t;

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          pop;
  logic          push;
  fetch_state_t  state;

  assign pc_out   = pc;
  assign if_valid = (count != '0);
  assign pop      = if_valid && id_ready;
  assign if_pc    = if_valid ? pc_mem[rd_ptr]    : 32'd0;
  assign if_instr = if_valid ? instr_mem[rd_ptr] : 32'd0;

  // HOLD is decoded from count/stall (no state register); a redirect forces FETCH with no push
  always_comb begin
    push  = 1'b0;
    state = FETCH;
    if (!redirect_valid) begin
      if (!stall_fetch && ((count < FULL_COUNT) || pop)) begin
        push = 1'b1;
      end else begin
        state = HOLD;
      end
    end
  end

  // PC, pointers and occupancy; a redirect wins and discards every entry not popped this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & 32'hFFFF_FFFC & PC_MASK;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (state == FETCH) begin
        pc     <= (pc + 32'd4) & PC_MASK;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // FIFO storage has no reset; the outputs are masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= instr_in;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating event counters for fetches, blocked fetch cycles and flushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (push && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if ((state == HOLD) && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (redirect_valid && (perf_flush != '1)) begin
        perf_flush <= perf_flush + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: drives instruction_fetch against a small behavioural
// memory. A queue holds the expected {pc, instr} pairs in fetch order, and each
// pair is compared when decode pops it.
module tb_instruction_fetch;

  localparam int unsigned IMEM_BYTES = 32;
  localparam int unsigned DEPTH      = 2;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] PC_MASK    = 32'(IMEM_BYTES - 1);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        stall_fetch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  logic [31:0] imem [8];
  entry_t      sb [$];
  logic [31:0] model_pc;
  int          model_fetched;
  int          model_stall;
  int          model_flush;
  int          tests_run;
  int          tests_failed;

  instruction_fetch #(
    .IMEM_BYTES(IMEM_BYTES),
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc_out(pc_out),
    .instr_in(instr_in),
    .stall_fetch(stall_fetch),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .id_ready(id_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  assign instr_in = imem[pc_out[4:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    sb.delete();
    model_pc      = RESET_PC;
    model_fetched = 0;
    model_stall   = 0;
    model_flush   = 0;
  endtask

  // Called just after a falling edge: drive, check, advance the model, wait one cycle
  task automatic applyStimulus(input logic stall, input logic redir,
                               input logic [31:0] rpc, input logic rdy);
    logic pop;
    logic push;
    stall_fetch    = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
    checkOutput("pc_out", pc_out, model_pc);
    checkOutput("if_valid", {31'd0, if_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      checkOutput("if_pc", if_pc, sb[0].pc);
      checkOutput("if_instr", if_instr, sb[0].instr);
    end else begin
      checkOutput("if_pc_idle", if_pc, 32'd0);
    end
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched", perf_fetched, 32'(model_fetched));
    checkOutput("perf_stall", perf_stall, 32'(model_stall));
    checkOutput("perf_flush", {16'd0, perf_flush}, 32'(model_flush));
`endif
    pop  = (sb.size() != 0) && rdy;
    push = !redir && !stall && ((sb.size() < DEPTH) || pop);
    if (pop) void'(sb.pop_front());
    if (redir) begin
      sb.delete();
      model_pc = rpc & 32'hFFFF_FFFC & PC_MASK;
      model_flush++;
    end else if (push) begin
      sb.push_back('{pc: model_pc, instr: imem[model_pc[4:2]]});
      model_pc = (model_pc + 32'd4) & PC_MASK;
      model_fetched++;
    end else begin
      model_stall++;
    end
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    imem[0] = 32'h0094_0333;
    imem[1] = 32'h4139_03b3;
    for (int i = 2; i < 8; i++) imem[i] = 32'hA5A5_0000 | 32'(i * 4);
    reset          = 1'b0;
    stall_fetch    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b0;
    modelReset();

    @(negedge clk);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_instr", if_instr, 32'd0);
    checkOutput("rst_pc_out", pc_out, RESET_PC);
    @(negedge clk);
    reset = 1'b1;

    // Streaming with decode always ready
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    // Decode backpressure fills the FIFO and freezes the PC
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    // Drain and run past the end of memory
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    // Fetch stall while decode drains
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    // Fill two entries, then redirect while popping the head
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    // Redirect beats a simultaneous stall; out-of-range target wraps
    applyStimulus(1'b1, 1'b1, 32'h0000_0107, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    // Mixed random traffic
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                    $urandom, ($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset between edges while entries are pending
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("async_pc_out", pc_out, RESET_PC);
    checkOutput("async_if_pc", if_pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
